arith_control_seq: RTL and testbench
====================================

ARITH_CONTROL_SEQ -- requirements
Module: arithControlSeq

Interface
REQ-001 Parameter WIDTH, default 32, operand and HI/LO width; legal range 8..64.
REQ-002 clock  in  1  rising-edge clock.
REQ-003 reset  in  1  asynchronous, active-low reset.
REQ-004 start  in  1  instruction valid this cycle.
REQ-005 aluOp  in  4  libAritimeticalControl ARCTRL_* code.
REQ-006 func  in  6  R-type function field (libFunctions FUNC_*).
REQ-007 opA, opB  in  WIDTH each  rs and rt operand values.
REQ-008 aluControl  out  4  libAlu ALU_* code for the ALU.
REQ-009 busy  out  1  stall request to hold PC and register writes.
REQ-010 hi, lo  out  WIDTH each  HI and LO register contents.
REQ-011 hiLoWrite  out  1  one-cycle pulse on the cycle HI/LO take a new value.
REQ-012 done  out  1  one-cycle completion pulse for MULT, MULTU, DIV and DIVU.
REQ-013 divByZero  out  1  one-cycle pulse, coincident with done, when the divisor is 0.

Function
REQ-014 aluControl is combinational from aluOp/func using the existing ARCTRL/FUNC-to-ALU table (ADD, SUB, AND, OR, XOR, SLT, SLLV, SRLV, SRAV, MFHI, MFLO, LU); MULT, MULTU, DIV and DIVU map to ALU_ZERO; unknown codes map to ALU_ZERO.
REQ-015 Only the FSM states IDLE, MUL, DIV and DONE are legal.
REQ-016 Accept: in IDLE, start=1 with aluOp=ARCTRL_FUNC and func in {MULT 0x18, MULTU 0x19, DIV 0x1A, DIVU 0x1B} latches the operands and signedness at the edge (edge E).
REQ-017 A multiply accept goes to MUL; a divide with opB!=0 goes to DIV; a divide with opB==0 goes directly to DONE.
REQ-018 MUL and DIV run exactly WIDTH iterations on operand magnitudes: shift-add multiply or restoring divide, with a counter of $clog2(WIDTH)+1 bits.
REQ-019 On the edge after the last iteration, the sign is fixed, HI/LO are written, and the FSM enters DONE.
REQ-020 HI/LO update at edge E+WIDTH+1; hiLoWrite=1 and done=1 during the following cycle, in DONE; DONE returns to IDLE on the next edge.
REQ-021 Multiply: {hi,lo} = the full 2*WIDTH-bit product; MULT is signed, MULTU is unsigned.
REQ-022 Divide: lo = quotient truncated toward zero; hi = remainder carrying the dividend's sign.
REQ-023 Signed MIN/-1 divide gives lo=MIN, hi=0.
REQ-024 Divide by zero: HI/LO are unchanged, hiLoWrite=0, and done=divByZero=1 during the cycle after edge E+1.
REQ-025 busy = (state is MUL or DIV) OR (state is IDLE AND a REQ-016 accept condition is true, combinationally); busy is 0 in DONE.
REQ-026 MTHI (0x11) / MTLO (0x13) with start=1 in IDLE write opA into hi/lo at that edge, in one cycle with no busy; hiLoWrite pulses the cycle after the write.
REQ-027 start while in MUL, DIV or DONE is ignored: no state, operand or HI/LO change; the upstream holds the instruction by means of busy.
REQ-028 hi/lo read as the pre-operation values until the write edge; MFHI/MFLO issued in DONE see the new values.

Reset
REQ-029 While reset=0: state=IDLE, counter=0, hi=lo=0, busy=done=hiLoWrite=divByZero=0, and internal operand/accumulator registers are 0.
REQ-030 Reset asserted mid-operation aborts the operation immediately, with no HI/LO write and no done.
REQ-031 The first edge after reset deassertion can accept a new start.

Verification
REQ-032 WIDTH=32, MULT opA=0xFFFFFFFF opB=0x00000002 -> hi=0xFFFFFFFF, lo=0xFFFFFFFE; done exactly 33 edges after accept; busy high for the 33 cycles.
REQ-033 MULTU with the same operands -> hi=0x00000001, lo=0xFFFFFFFE.
REQ-034 DIV opA=0xFFFFFFF9 (-7) opB=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF; DIV 0x80000000/0xFFFFFFFF -> lo=0x80000000, hi=0.
REQ-035 DIV 5/0 with prior hi=0x11, lo=0x22 -> done=divByZero=1 one cycle after accept, hiLoWrite=0, hi/lo unchanged.
REQ-036 Reset low after 10 iterations of a MULT -> busy=0, hi=lo=0, no done pulse; a MULTU 3*4 started after release -> lo=12, hi=0.
REQ-037 Second MULT start held high during busy -> exactly one operation performed; MTLO opA=0x55 -> lo=0x55 next edge, busy never asserted; func=FUNC_ADD -> aluControl=ALU_ADD, busy=0.

Source files
------------

// File: rtl/arith_control_seq.sv
// Decoder from ALU op and function field to ALU code, plus a multi-cycle MULT/MULTU/DIV/DIVU sequencer.
// HI/LO live here; the sequencer uses shift-add multiply and restoring divide on operand magnitudes.
module arith_control_seq #(
   parameter int unsigned WIDTH = 32
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             start,
   input  logic [3:0]       aluOp,
   input  logic [5:0]       func,
   input  logic [WIDTH-1:0] opA,
   input  logic [WIDTH-1:0] opB,
   output logic [3:0]       aluControl,
   output logic             busy,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo,
   output logic             hiLoWrite,
   output logic             done,
   output logic             divByZero
);

   localparam logic [3:0] ARCTRL_ADD  = 4'd0;
   localparam logic [3:0] ARCTRL_SUB  = 4'd1;
   localparam logic [3:0] ARCTRL_AND  = 4'd2;
   localparam logic [3:0] ARCTRL_OR   = 4'd3;
   localparam logic [3:0] ARCTRL_SLT  = 4'd4;
   localparam logic [3:0] ARCTRL_LU   = 4'd5;
   localparam logic [3:0] ARCTRL_XOR  = 4'd6;
   localparam logic [3:0] ARCTRL_FUNC = 4'd7;

   localparam logic [5:0] FUNC_SLLV  = 6'h04;
   localparam logic [5:0] FUNC_SRLV  = 6'h06;
   localparam logic [5:0] FUNC_SRAV  = 6'h07;
   localparam logic [5:0] FUNC_MFHI  = 6'h10;
   localparam logic [5:0] FUNC_MTHI  = 6'h11;
   localparam logic [5:0] FUNC_MFLO  = 6'h12;
   localparam logic [5:0] FUNC_MTLO  = 6'h13;
   localparam logic [5:0] FUNC_MULT  = 6'h18;
   localparam logic [5:0] FUNC_MULTU = 6'h19;
   localparam logic [5:0] FUNC_DIV   = 6'h1A;
   localparam logic [5:0] FUNC_DIVU  = 6'h1B;
   localparam logic [5:0] FUNC_ADD   = 6'h20;
   localparam logic [5:0] FUNC_ADDU  = 6'h21;
   localparam logic [5:0] FUNC_SUB   = 6'h22;
   localparam logic [5:0] FUNC_SUBU  = 6'h23;
   localparam logic [5:0] FUNC_AND   = 6'h24;
   localparam logic [5:0] FUNC_OR    = 6'h25;
   localparam logic [5:0] FUNC_XOR   = 6'h26;
   localparam logic [5:0] FUNC_SLT   = 6'h2A;

   localparam logic [3:0] ALU_ZERO = 4'd0;
   localparam logic [3:0] ALU_ADD  = 4'd1;
   localparam logic [3:0] ALU_SUB  = 4'd2;
   localparam logic [3:0] ALU_AND  = 4'd3;
   localparam logic [3:0] ALU_OR   = 4'd4;
   localparam logic [3:0] ALU_XOR  = 4'd5;
   localparam logic [3:0] ALU_SLT  = 4'd6;
   localparam logic [3:0] ALU_SLLV = 4'd7;
   localparam logic [3:0] ALU_SRLV = 4'd8;
   localparam logic [3:0] ALU_SRAV = 4'd9;
   localparam logic [3:0] ALU_MFHI = 4'd10;
   localparam logic [3:0] ALU_MFLO = 4'd11;
   localparam logic [3:0] ALU_LU   = 4'd12;

   localparam int unsigned CW = $clog2(WIDTH) + 1;

   typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;

   state_t             state;
   logic [CW-1:0]      cnt;
   logic [WIDTH:0]     acc;
   logic [WIDTH-1:0]   qreg, breg;
   logic               neg_q, neg_r, dz;

   logic               is_func, is_mul, is_div, accept, is_signed;
   logic [WIDTH-1:0]   mag_a, mag_b;
   logic [WIDTH:0]     mul_sum, div_shift, div_diff;
   logic [2*WIDTH-1:0] prod, res_mul;
   logic [WIDTH-1:0]   res_q, res_r;

   always_comb begin
      aluControl = ALU_ZERO;
      case (aluOp)
         ARCTRL_ADD:  aluControl = ALU_ADD;
         ARCTRL_SUB:  aluControl = ALU_SUB;
         ARCTRL_AND:  aluControl = ALU_AND;
         ARCTRL_OR:   aluControl = ALU_OR;
         ARCTRL_XOR:  aluControl = ALU_XOR;
         ARCTRL_SLT:  aluControl = ALU_SLT;
         ARCTRL_LU:   aluControl = ALU_LU;
         ARCTRL_FUNC: begin
            case (func)
               FUNC_ADD, FUNC_ADDU: aluControl = ALU_ADD;
               FUNC_SUB, FUNC_SUBU: aluControl = ALU_SUB;
               FUNC_AND:  aluControl = ALU_AND;
               FUNC_OR:   aluControl = ALU_OR;
               FUNC_XOR:  aluControl = ALU_XOR;
               FUNC_SLT:  aluControl = ALU_SLT;
               FUNC_SLLV: aluControl = ALU_SLLV;
               FUNC_SRLV: aluControl = ALU_SRLV;
               FUNC_SRAV: aluControl = ALU_SRAV;
               FUNC_MFHI: aluControl = ALU_MFHI;
               FUNC_MFLO: aluControl = ALU_MFLO;
               default:   aluControl = ALU_ZERO;
            endcase
         end
         default: aluControl = ALU_ZERO;
      endcase
   end

   // Odd function codes in 0x18..0x1B are the unsigned variants.
   assign is_func   = (aluOp == ARCTRL_FUNC);
   assign is_mul    = is_func && (func == FUNC_MULT || func == FUNC_MULTU);
   assign is_div    = is_func && (func == FUNC_DIV || func == FUNC_DIVU);
   assign accept    = (state == IDLE) && start && (is_mul || is_div);
   assign busy      = (state == MUL) || (state == DIV) || accept;
   assign is_signed = ~func[0];
   assign mag_a     = (is_signed && opA[WIDTH-1]) ? -opA : opA;
   assign mag_b     = (is_signed && opB[WIDTH-1]) ? -opB : opB;

   assign mul_sum   = qreg[0] ? acc + {1'b0, breg} : acc;
   assign div_shift = {acc[WIDTH-1:0], qreg[WIDTH-1]};
   assign div_diff  = div_shift - {1'b0, breg};
   assign prod      = {acc[WIDTH-1:0], qreg};
   assign res_mul   = neg_q ? -prod : prod;
   assign res_q     = neg_q ? -qreg : qreg;
   assign res_r     = neg_r ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state     <= IDLE;
         cnt       <= '0;
         acc       <= '0;
         qreg      <= '0;
         breg      <= '0;
         neg_q     <= 1'b0;
         neg_r     <= 1'b0;
         dz        <= 1'b0;
         hi        <= '0;
         lo        <= '0;
         hiLoWrite <= 1'b0;
         done      <= 1'b0;
         divByZero <= 1'b0;
      end else begin
         hiLoWrite <= 1'b0;
         done      <= 1'b0;
         divByZero <= 1'b0;
         case (state)
            IDLE: begin
               if (accept) begin
                  acc   <= '0;
                  qreg  <= mag_a;
                  breg  <= mag_b;
                  cnt   <= '0;
                  neg_q <= is_signed && (opA[WIDTH-1] ^ opB[WIDTH-1]);
                  neg_r <= is_signed && opA[WIDTH-1];
                  if (is_mul)
                     state <= MUL;
                  else if (opB == '0) begin
                     state <= DONE;
                     dz    <= 1'b1;
                  end else
                     state <= DIV;
               end else if (start && is_func && func == FUNC_MTHI) begin
                  hi        <= opA;
                  hiLoWrite <= 1'b1;
               end else if (start && is_func && func == FUNC_MTLO) begin
                  lo        <= opA;
                  hiLoWrite <= 1'b1;
               end
            end
            MUL: begin
               if (cnt == CW'(WIDTH)) begin
                  {hi, lo}  <= res_mul;
                  hiLoWrite <= 1'b1;
                  done      <= 1'b1;
                  state     <= DONE;
               end else begin
                  {acc, qreg} <= {mul_sum, qreg} >> 1;
                  cnt         <= cnt + 1'b1;
               end
            end
            DIV: begin
               if (cnt == CW'(WIDTH)) begin
                  lo        <= res_q;
                  hi        <= res_r;
                  hiLoWrite <= 1'b1;
                  done      <= 1'b1;
                  state     <= DONE;
               end else begin
                  acc  <= div_diff[WIDTH] ? div_shift : div_diff;
                  qreg <= {qreg[WIDTH-2:0], ~div_diff[WIDTH]};
                  cnt  <= cnt + 1'b1;
               end
            end
            DONE: begin
               // A zero divisor reports on the exit edge, one edge after acceptance.
               state <= IDLE;
               if (dz) begin
                  done      <= 1'b1;
                  divByZero <= 1'b1;
                  dz        <= 1'b0;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_arith_control_seq.sv
// Bench for arith_control_seq: decode table, directed multi-cycle corner cases, randomized ops vs. a 64-bit arithmetic model.
module tb_arith_control_seq;

   localparam logic [3:0] ARCTRL_ADD = 4'd0, ARCTRL_SUB = 4'd1, ARCTRL_AND = 4'd2, ARCTRL_OR = 4'd3,
                          ARCTRL_SLT = 4'd4, ARCTRL_LU = 4'd5, ARCTRL_XOR = 4'd6, ARCTRL_FUNC = 4'd7;
   localparam logic [5:0] F_SLLV = 6'h04, F_SRLV = 6'h06, F_SRAV = 6'h07, F_MFHI = 6'h10, F_MTHI = 6'h11,
                          F_MFLO = 6'h12, F_MTLO = 6'h13, F_MULT = 6'h18, F_MULTU = 6'h19, F_DIV = 6'h1A,
                          F_DIVU = 6'h1B, F_ADD = 6'h20, F_SUB = 6'h22, F_AND = 6'h24, F_XOR = 6'h26;
   localparam logic [3:0] A_ZERO = 4'd0, A_ADD = 4'd1, A_SUB = 4'd2, A_AND = 4'd3, A_OR = 4'd4, A_XOR = 4'd5,
                          A_SLT = 4'd6, A_SLLV = 4'd7, A_SRLV = 4'd8, A_SRAV = 4'd9, A_MFHI = 4'd10,
                          A_MFLO = 4'd11, A_LU = 4'd12;

   logic        clock = 1'b0, reset = 1'b0, start = 1'b0;
   logic [3:0]  aluOp = '0;
   logic [5:0]  func = '0;
   logic [31:0] opA = '0, opB = '0;
   logic [3:0]  aluControl;
   logic        busy, hiLoWrite, done, divByZero;
   logic [31:0] hi, lo;

   int tests = 0, fails = 0;
   logic [31:0] m_hi = '0, m_lo = '0;

   arith_control_seq #(.WIDTH(32)) dut (
      .clock(clock), .reset(reset), .start(start), .aluOp(aluOp), .func(func),
      .opA(opA), .opB(opB), .aluControl(aluControl), .busy(busy), .hi(hi), .lo(lo),
      .hiLoWrite(hiLoWrite), .done(done), .divByZero(divByZero));

   always #5 clock = ~clock;

   typedef struct {
      logic [3:0] op;
      logic [5:0] fn;
      logic [3:0] alu;
      logic       bsy;
   } vec_t;
   vec_t tbl[$];

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic move_to(input logic [5:0] f, input logic [31:0] v);
      start = 1'b1; aluOp = ARCTRL_FUNC; func = f; opA = v; #1;
      check("mt_busy", busy, 0);
      tick();
      start = 1'b0;
      if (f == F_MTHI) m_hi = v; else m_lo = v;
      check("mt_hi", hi, m_hi);
      check("mt_lo", lo, m_lo);
      check("mt_pulse", hiLoWrite, 1);
      tick();
      check("mt_pulse_end", {hiLoWrite, busy, done}, 0);
   endtask

   task automatic run_op(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b);
      longint sa, sb;
      logic [63:0] p;
      logic [31:0] eh, el;
      logic dz;
      int lat, n, bad;
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      eh = m_hi; el = m_lo; dz = 1'b0;
      case (f)
         F_MULT:  begin p = sa * sb; eh = p[63:32]; el = p[31:0]; end
         F_MULTU: begin p = {32'd0, a} * {32'd0, b}; eh = p[63:32]; el = p[31:0]; end
         F_DIV:   if (b == 0) dz = 1'b1;
                  else begin p = sa / sb; el = p[31:0]; p = sa % sb; eh = p[31:0]; end
         default: if (b == 0) dz = 1'b1;
                  else begin el = a / b; eh = a % b; end
      endcase
      lat = dz ? 1 : 33;
      start = 1'b1; aluOp = ARCTRL_FUNC; func = f; opA = a; opB = b; #1;
      check("accept_busy", busy, 1);
      tick();
      start = 1'b0;
      n = 0; bad = 0;
      while (done !== 1'b1 && n < lat + 4) begin
         if (busy !== !dz || hiLoWrite !== 1'b0 || divByZero !== 1'b0 || hi !== m_hi || lo !== m_lo) bad++;
         tick();
         n++;
      end
      check("op_quiet", bad, 0);
      check("op_latency", n, lat);
      check("op_done", done, 1);
      check("op_divByZero", divByZero, dz);
      check("op_hiLoWrite", hiLoWrite, !dz);
      check("op_busy_end", busy, 0);
      check("op_hi", hi, eh);
      check("op_lo", lo, el);
      m_hi = eh; m_lo = el;
      tick();
      check("op_pulse_end", {done, hiLoWrite, divByZero}, 0);
   endtask

   initial begin
      int n, extra, mode;
      logic [5:0]  rf;
      logic [31:0] ra, rb;

      repeat (3) @(posedge clock);
      #1;
      check("rst_outputs", {busy, done, hiLoWrite, divByZero}, 0);
      check("rst_hilo", {hi, lo}, 0);
      reset = 1'b1;
      tick();

      tbl.push_back(vec_t'{ARCTRL_ADD, 6'h00, A_ADD, 1'b0});
      tbl.push_back(vec_t'{ARCTRL_SUB, 6'h00, A_SUB, 1'b0});
      tbl.push_back(vec_t'{ARCTRL_AND, 6'h18, A_AND, 1'b0});
      tbl.push_back(vec_t'{ARCTRL_OR,  6'h00, A_OR,  1'b0});
      tbl.push_back(vec_t'{ARCTRL_XOR, 6'h00, A_XOR, 1'b0});
      tbl.push_back(vec_t'{ARCTRL_SLT, 6'h00, A_SLT, 1'b0});
      tbl.push_back(vec_t'{ARCTRL_LU,  6'h00, A_LU,  1'b0});
      tbl.push_back(vec_t'{ARCTRL_FUNC, F_ADD,  A_ADD,  1'b0});
      tbl.push_back(vec_t'{ARCTRL_FUNC, F_SUB,  A_SUB,  1'b0});
      tbl.push_back(vec_t'{ARCTRL_FUNC, F_AND,  A_AND,  1'b0});
      tbl.push_back(vec_t'{ARCTRL_FUNC, F_XOR,  A_XOR,  1'b0});
      tbl.push_back(vec_t'{ARCTRL_FUNC, F_SLLV, A_SLLV, 1'b0});
      tbl.push_back(vec_t'{ARCTRL_FUNC, F_SRLV, A_SRLV, 1'b0});
      tbl.push_back(vec_t'{ARCTRL_FUNC, F_SRAV, A_SRAV, 1'b0});
      tbl.push_back(vec_t'{ARCTRL_FUNC, F_MFHI, A_MFHI, 1'b0});
      tbl.push_back(vec_t'{ARCTRL_FUNC, F_MFLO, A_MFLO, 1'b0});
      tbl.push_back(vec_t'{ARCTRL_FUNC, F_MULT, A_ZERO, 1'b1});
      tbl.push_back(vec_t'{ARCTRL_FUNC, F_DIVU, A_ZERO, 1'b1});
      tbl.push_back(vec_t'{ARCTRL_FUNC, F_MTLO, A_ZERO, 1'b0});
      tbl.push_back(vec_t'{ARCTRL_FUNC, 6'h3F,  A_ZERO, 1'b0});
      tbl.push_back(vec_t'{4'hF,        F_MULT, A_ZERO, 1'b0});
      foreach (tbl[i]) begin
         start = 1'b1; aluOp = tbl[i].op; func = tbl[i].fn; #1;
         check($sformatf("dec%0d_alu", i), aluControl, tbl[i].alu);
         check($sformatf("dec%0d_busy", i), busy, tbl[i].bsy);
         start = 1'b0;
         tick();
      end
      check("dec_no_side_effect", {hi, lo, done, hiLoWrite}, 0);

      move_to(F_MTLO, 32'h55);
      run_op(F_MULT,  32'hFFFFFFFF, 32'h00000002);
      run_op(F_MULTU, 32'hFFFFFFFF, 32'h00000002);
      run_op(F_DIV,   32'hFFFFFFF9, 32'h00000002);
      run_op(F_DIV,   32'h80000000, 32'hFFFFFFFF);
      run_op(F_DIVU,  32'h80000000, 32'hFFFFFFFF);
      move_to(F_MTHI, 32'h11);
      move_to(F_MTLO, 32'h22);
      run_op(F_DIV,   32'h00000005, 32'h00000000);
      run_op(F_DIVU,  32'h00000009, 32'h00000000);

      // Reset in the middle of a multiply.
      start = 1'b1; aluOp = ARCTRL_FUNC; func = F_MULT; opA = 32'h1234; opB = 32'h5678;
      tick();
      start = 1'b0;
      repeat (10) tick();
      reset = 1'b0; #1;
      m_hi = '0; m_lo = '0;
      check("midrst_outputs", {busy, done, hiLoWrite, divByZero}, 0);
      check("midrst_hilo", {hi, lo}, 0);
      extra = 0;
      repeat (2) begin tick(); if (done !== 1'b0) extra++; end
      reset = 1'b1;
      run_op(F_MULTU, 32'd3, 32'd4);

      // Start held through the whole operation with operands changing underneath.
      start = 1'b1; aluOp = ARCTRL_FUNC; func = F_MULT; opA = 32'd7; opB = 32'hFFFFFFFD;
      tick();
      opA = 32'd100; opB = 32'd100;
      n = 0;
      while (done !== 1'b1 && n < 40) begin tick(); n++; end
      start = 1'b0;
      check("hold_latency", n, 33);
      check("hold_hi", hi, 32'hFFFFFFFF);
      check("hold_lo", lo, 32'hFFFFFFEB);
      m_hi = 32'hFFFFFFFF; m_lo = 32'hFFFFFFEB;
      repeat (40) begin tick(); if (done !== 1'b0) extra++; end
      check("no_extra_done", extra, 0);

      for (int k = 0; k < 40; k++) begin
         rf = F_MULT + 6'($urandom_range(0, 3));
         mode = $urandom_range(0, 7);
         ra = (mode == 0) ? 32'h80000000 : 32'($urandom);
         mode = $urandom_range(0, 7);
         rb = (mode == 0) ? 32'd0 : (mode == 1) ? 32'hFFFFFFFF : (mode == 2) ? 32'd1 :
              (mode == 3) ? 32'($urandom_range(1, 255)) : 32'($urandom);
         run_op(rf, ra, rb);
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: got running expected finished");
      $fatal(1);
   end

endmodule
